// File: rtl/fft_pkg.sv
// Shared types and helpers for the ping-pong FFT sample memory.
// Holds the bank-state encoding, default widths and the fill-address bit reversal.
package fft_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_BUSY    = 2'd3
    } bank_state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        int          j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            j = w - 1 - i;
            if (i < w) r[i] = v[j[4:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One bank: single-port RAM with a synchronous 1-cycle read.
// A write leaves dout unchanged, so the last read value is held.
module fft_bank_ram #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= din;
    end

    // Only the output register is reset; the array contents are left alone.
    always_ff @(posedge clk) begin
        if (reset)           dout <= '0;
        else if (en && !we)  dout <= mem[addr];
    end

endmodule

// File: rtl/fft_pingpong_ram.sv
// Two-bank complex-sample buffer between a streaming producer and an in-place FFT engine.
// Each bank moves FREE -> FILLING -> FULL -> BUSY -> FREE; fill and engine never share a bank.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BITREV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_re,
    input  logic [DATA_W-1:0]   in_im,
    output logic                overrun,
    output logic                full_valid,
    input  logic                eng_start,
    input  logic                eng_done,
    output logic                eng_busy,
    output logic                eng_bank,
    input  logic                eng_ce,
    input  logic                eng_wre,
    input  logic [ADDR_W-1:0]   eng_ad,
    input  logic [2*DATA_W-1:0] eng_din,
    output logic [2*DATA_W-1:0] eng_dout
);

    localparam int WORD_W = 2 * DATA_W;

    bank_state_t       state_q   [2];
    bank_state_t       state_nxt [2];
    logic              fill_bank;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] fill_addr;
    logic              rd_bank;

    logic              accept;
    logic              fill_last;
    logic              start_ok;
    logic              done_ok;
    logic              eng_en;

    logic [1:0]        ram_en;
    logic [1:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr [2];
    logic [WORD_W-1:0] ram_din  [2];
    logic [WORD_W-1:0] ram_dout [2];

    assign in_ready   = !reset && (state_q[fill_bank] == BANK_FREE ||
                                   state_q[fill_bank] == BANK_FILLING);
    assign accept     = in_valid && in_ready;
    assign fill_last  = (fill_cnt == '1);
    assign full_valid = (state_q[eng_bank] == BANK_FULL) && !eng_busy;
    assign start_ok   = eng_start && full_valid;
    assign done_ok    = eng_done && eng_busy;
    assign eng_en     = eng_ce && eng_busy;
    assign fill_addr  = (BITREV != 0) ? ADDR_W'(bitrev(32'(fill_cnt), ADDR_W)) : fill_cnt;

    // Fill and engine events always target different banks, so they compose freely.
    always_comb begin
        state_nxt[0] = state_q[0];
        state_nxt[1] = state_q[1];
        if (accept)   state_nxt[fill_bank] = fill_last ? BANK_FULL : BANK_FILLING;
        if (start_ok) state_nxt[eng_bank]  = BANK_BUSY;
        if (done_ok)  state_nxt[eng_bank]  = BANK_FREE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= BANK_FREE;
            state_q[1] <= BANK_FREE;
        end else begin
            state_q[0] <= state_nxt[0];
            state_q[1] <= state_nxt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_bank <= 1'b0;
            fill_cnt  <= '0;
            eng_bank  <= 1'b0;
            eng_busy  <= 1'b0;
            overrun   <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            if (accept) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_last) fill_bank <= ~fill_bank;
            end
            if (start_ok) eng_busy <= 1'b1;
            if (done_ok) begin
                eng_busy <= 1'b0;
                eng_bank <= ~eng_bank;
            end
            if (in_valid && !in_ready) overrun <= 1'b1;
            if (eng_en && !eng_wre)    rd_bank <= eng_bank;
        end
    end

    // The engine drives the bank it owns; every other bank belongs to the fill path.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (eng_busy && eng_bank == 1'(b)) begin
                ram_en[b]   = eng_en;
                ram_we[b]   = eng_wre;
                ram_addr[b] = eng_ad;
                ram_din[b]  = eng_din;
            end else begin
                ram_en[b]   = accept && fill_bank == 1'(b);
                ram_we[b]   = 1'b1;
                ram_addr[b] = fill_addr;
                ram_din[b]  = {in_re, in_im};
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_bank_ram #(
            .ADDR_W (ADDR_W),
            .WORD_W (WORD_W)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .en    (ram_en[g]),
            .we    (ram_we[g]),
            .addr  (ram_addr[g]),
            .din   (ram_din[g]),
            .dout  (ram_dout[g])
        );
    end

    assign eng_dout = ram_dout[rd_bank];

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram with ADDR_W=3, DATA_W=16, BITREV=1.
// Engine accesses come from a vector table; fill/ownership corners are hand-written sequences.
module tb_fft_pingpong_ram;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int WORD_W = 32;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              overrun;
    logic              full_valid;
    logic              eng_start;
    logic              eng_done;
    logic              eng_busy;
    logic              eng_bank;
    logic              eng_ce;
    logic              eng_wre;
    logic [ADDR_W-1:0] eng_ad;
    logic [WORD_W-1:0] eng_din;
    logic [WORD_W-1:0] eng_dout;

    int n_cmp = 0;
    int n_err = 0;

    fft_pingpong_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BITREV (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .overrun    (overrun),
        .full_valid (full_valid),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_busy   (eng_busy),
        .eng_bank   (eng_bank),
        .eng_ce     (eng_ce),
        .eng_wre    (eng_wre),
        .eng_ad     (eng_ad),
        .eng_din    (eng_din),
        .eng_dout   (eng_dout)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic              ce;
        logic              wre;
        logic [ADDR_W-1:0] ad;
        logic [WORD_W-1:0] din;
        logic [WORD_W-1:0] exp_dout;
    } eng_vec_t;

    eng_vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic eng_op(input logic ce, input logic wre, input logic [ADDR_W-1:0] ad,
                          input logic [WORD_W-1:0] din);
        eng_ce  = ce;
        eng_wre = wre;
        eng_ad  = ad;
        eng_din = din;
        tick();
        eng_ce  = 1'b0;
        eng_wre = 1'b0;
    endtask

    task automatic fill8(input int re_base, input logic neg_im);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re    = 16'(re_base + k);
            in_im    = neg_im ? 16'(0 - k) : 16'(k);
            check($sformatf("fill_ready_%0d", k), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        eng_start = 1'b1;
        tick();
        eng_start = 1'b0;
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
    endtask

    initial begin
        int acc;

        // bank0 holds re=k, im=-k at bitrev(k)
        vecs[0] = '{1'b1, 1'b0, 3'd1, 32'h0, 32'h0004_FFFC};
        vecs[1] = '{1'b1, 1'b0, 3'd0, 32'h0, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 3'd3, 32'h0, 32'h0006_FFFA};
        vecs[3] = '{1'b1, 1'b0, 3'd6, 32'h0, 32'h0003_FFFD};
        vecs[4] = '{1'b1, 1'b0, 3'd5, 32'h0, 32'h0005_FFFB};
        vecs[5] = '{1'b1, 1'b1, 3'd5, 32'h1234_ABCD, 32'h0005_FFFB};
        vecs[6] = '{1'b0, 1'b0, 3'd5, 32'h0, 32'h0005_FFFB};
        vecs[7] = '{1'b1, 1'b0, 3'd5, 32'h0, 32'h1234_ABCD};
        vecs[8] = '{1'b1, 1'b0, 3'd7, 32'h0, 32'h0007_FFF9};
        vecs[9] = '{1'b1, 1'b0, 3'd2, 32'h0, 32'h0002_FFFE};

        reset = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        eng_start = 1'b0; eng_done = 1'b0; eng_ce = 1'b0; eng_wre = 1'b0;
        eng_ad = '0; eng_din = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_eng_busy", 32'(eng_busy), 32'd0);
        check("rst_eng_dout", eng_dout, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_full_valid", 32'(full_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ignored engine commands while nothing is full or claimed
        pulse_start();
        check("ign_start_busy", 32'(eng_busy), 32'd0);
        pulse_done();
        check("ign_done_bank", 32'(eng_bank), 32'd0);

        fill8(0, 1'b1);
        check("fill0_full_valid", 32'(full_valid), 32'd1);
        check("fill0_eng_bank", 32'(eng_bank), 32'd0);
        check("fill0_in_ready", 32'(in_ready), 32'd1);

        // engine access before claiming must be gated off
        eng_op(1'b1, 1'b1, 3'd1, 32'hDEAD_BEEF);
        check("gated_dout", eng_dout, 32'd0);
        pulse_done();
        check("ign_done2_bank", 32'(eng_bank), 32'd0);
        check("ign_done2_full", 32'(full_valid), 32'd1);

        pulse_start();
        check("start_busy", 32'(eng_busy), 32'd1);
        check("start_full_valid", 32'(full_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            eng_op(vecs[i].ce, vecs[i].wre, vecs[i].ad, vecs[i].din);
            check($sformatf("vec_%0d", i), eng_dout, vecs[i].exp_dout);
        end

        // producer streams while bank0 is busy: only bank1 can take samples
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = in_ready;
            in_re    = 16'(100 + acc);
            in_im    = 16'(acc);
            if (in_valid) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("stream_accepted", 32'(acc), 32'd8);
        check("stream_in_ready", 32'(in_ready), 32'd0);
        check("stream_overrun0", 32'(overrun), 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);

        pulse_done();
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("done_eng_bank", 32'(eng_bank), 32'd1);
        check("done_eng_busy", 32'(eng_busy), 32'd0);
        check("done_full_valid", 32'(full_valid), 32'd1);

        pulse_start();
        eng_op(1'b1, 1'b0, 3'd1, 32'h0);
        check("bank1_rd1", eng_dout, 32'h0068_0004);

        // bank0 fill completes on the same edge that bank1 is released
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re    = 16'(50 + k);
            in_im    = 16'(k);
            eng_done = (k == 7);
            tick();
        end
        in_valid = 1'b0;
        eng_done = 1'b0;
        check("simul_full_valid", 32'(full_valid), 32'd1);
        check("simul_eng_bank", 32'(eng_bank), 32'd0);
        check("simul_eng_busy", 32'(eng_busy), 32'd0);
        check("simul_in_ready", 32'(in_ready), 32'd1);

        pulse_start();
        eng_op(1'b1, 1'b0, 3'd3, 32'h0);
        check("bank0_rd3", eng_dout, 32'h0038_0006);

        // partial fill of bank1, then reset at fill_cnt=5
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_re    = 16'(300 + k);
            in_im    = 16'(k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("mrst_eng_busy", 32'(eng_busy), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        check("mrst_eng_dout", eng_dout, 32'd0);
        check("mrst_full_valid", 32'(full_valid), 32'd0);
        check("mrst_eng_bank", 32'(eng_bank), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);

        fill8(200, 1'b0);
        check("refill_full_valid", 32'(full_valid), 32'd1);
        pulse_start();
        eng_op(1'b1, 1'b0, 3'd6, 32'h0);
        check("refill_rd6", eng_dout, 32'h00CB_0003);
        eng_op(1'b1, 1'b0, 3'd4, 32'h0);
        check("refill_rd4", eng_dout, 32'h00C9_0001);
        eng_op(1'b1, 1'b0, 3'd0, 32'h0);
        check("refill_rd0", eng_dout, 32'h00C8_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
Double-buffered complex-sample memory that sits between the ADC/symbol sample stream and the in-place FFT engine. It holds two banks of 2^ADDR_W complex words. Word packing is real part in the upper DATA_W bits and imaginary part in the lower DATA_W bits. A streaming producer fills one bank while the FFT engine has exclusive random read/write access to the other. Bank ownership moves through a per-bank state machine.

Parameters:
ADDR_W, 11, bank address width; depth = 2^ADDR_W complex samples per bank
DATA_W, 16, width of each of the real and imaginary parts; word width = 2*DATA_W
BITREV, 1, 1 = fill addresses are bit-reversed (FFT input order); 0 = natural order

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer sample valid
in_ready  out  1  block can accept a sample this cycle
in_re  in  DATA_W  sample real part
in_im  in  DATA_W  sample imaginary part
overrun  out  1  sticky; set when in_valid=1 while in_ready=0
full_valid  out  1  bank eng_bank is FULL and the engine is idle
eng_start  in  1  engine claims bank eng_bank
eng_done  in  1  engine releases the claimed bank
eng_busy  out  1  engine owns a bank
eng_bank  out  1  index of the bank the engine owns or will own next
eng_ce  in  1  engine access enable
eng_wre  in  1  engine write enable (qualified by eng_ce)
eng_ad  in  ADDR_W  engine address
eng_din  in  2*DATA_W  engine write data {re, im}
eng_dout  out  2*DATA_W  engine read data {re, im}

Behaviour:
- Per-bank states are FREE, FILLING, FULL and BUSY.
- Internal registers: fill_bank (1b), fill_cnt (ADDR_W b), eng_bank (1b), eng_busy.
- Reset state: both banks FREE, fill_bank=0, eng_bank=0, fill_cnt=0.
- Reset values of outputs: eng_busy=0, eng_dout=0, overrun=0, full_valid=0, in_ready=0. in_ready=0 holds during the reset cycle. Reset mid-operation discards all bank contents logically; RAM contents are don't-care.
- in_ready = state[fill_bank] is FREE or FILLING, and reset is not asserted.
- Accept condition: in_valid & in_ready.
  - Write {in_re, in_im} to bank fill_bank at address bitrev(fill_cnt) if BITREV=1, else fill_cnt.
  - fill_cnt increments; a FREE bank goes to FILLING.
- Accept with fill_cnt = 2^ADDR_W-1:
  - bank goes to FULL, fill_cnt wraps to 0, fill_bank toggles.
  - If the other bank is FULL or BUSY, in_ready drops the next cycle.
- overrun: set on in_valid & ~in_ready; cleared only by reset.
- full_valid = (state[eng_bank]==FULL) & ~eng_busy, registered-state derived (combinational from state regs).
- eng_start while full_valid: bank eng_bank goes to BUSY, eng_busy=1 next cycle. eng_start otherwise is ignored.
- eng_done while eng_busy: bank goes to FREE, eng_busy=0, eng_bank toggles. eng_done otherwise is ignored. eng_start and eng_done cannot both be valid in the same cycle.
- Engine access is honoured only while eng_busy=1; otherwise eng_ce is gated off.
  - Read latency is 1 cycle: eng_dout is valid the cycle after eng_ce=1, eng_wre=0.
  - On a write cycle, and on idle cycles, eng_dout holds its value.
- Simultaneous events:
  - A fill completion on one bank and eng_done on the other in the same cycle both take effect.
  - A bank freed by eng_done becomes writable the next cycle; in_ready rises then.
- Ports never contend: the fill path and the engine path always address different banks.

Decomposition:
- Package fft_pkg: DATA_W/ADDR_W defaults, bank-state enum (FREE/FILLING/FULL/BUSY), and a bitrev function.
- One sub-module, fft_bank_ram: single-port, 2^ADDR_W x 2*DATA_W, sync 1-cycle read, normal write mode, inferable to BSRAM. It is instantiated twice, with address/data/we muxed by bank ownership.

Test Plan:
- Bench uses ADDR_W=3, DATA_W=16, BITREV=1.
- Fill with samples re=k, im=-k (k=0..7) -> bank0 FULL; full_valid=1; after eng_start, reading eng_ad=1 returns {16'd4, 16'hFFFC} (bitrev(4)=1), and reading eng_ad=0 returns {0,0}.
- Stream 16 samples continuously while the engine holds bank0 busy -> the first 8 fill bank1, then in_ready=0. A 17th in_valid sets overrun=1; eng_done lets in_ready rise next cycle and eng_bank=1.
- Engine writes eng_ad=5 with eng_din=32'h1234_ABCD, then reads eng_ad=5 -> eng_dout=32'h1234_ABCD exactly 1 cycle after the read; eng_dout is unchanged during the write cycle.
- eng_start with full_valid=0, and eng_done with eng_busy=0 -> no state change; an eng_ce write while not busy leaves RAM unchanged (verified by a later read).
- Assert reset mid-fill (fill_cnt=5) -> next cycle fill_cnt=0, banks FREE, eng_busy=0, overrun=0, eng_dout=0. A subsequent 8-sample fill lands in bank0 at addresses 0..7 in bitrev order.
